// File: rtl/laser_sweep_obstacle_if.sv
// Pixel-stream and status bundle between the rgb pipeline and laser_sweep_obstacle.
// master drives the pixel stream and selector; slave is the obstacle block.
interface laser_sweep_obstacle_if;
    logic [11:0] hcount_in;
    logic [11:0] vcount_in;
    logic [11:0] rgb_in;
    logic        game_on;
    logic [3:0]  selected;
    logic [11:0] rgb_out;
    logic [11:0] obstacle_x;
    logic [11:0] obstacle_y;
    logic        firing;
    logic        done;

    modport master (
        output hcount_in, vcount_in, rgb_in, game_on, selected,
        input  rgb_out, obstacle_x, obstacle_y, firing, done
    );

    modport slave (
        input  hcount_in, vcount_in, rgb_in, game_on, selected,
        output rgb_out, obstacle_x, obstacle_y, firing, done
    );
endinterface

// File: rtl/laser_sweep_obstacle.sv
// Sweeping multi-bar laser obstacle: WARN -> FIRE -> SHIFT rounds, then a done pulse.
// Optional macro LASER_WARN_BLINK_EN blinks the warning bars (8 frames on / 8 off).
module laser_sweep_obstacle #(
    parameter int          NUM_LASERS   = 3,
    parameter int          LASER_WIDTH  = 30,
    parameter int          SPACING      = 100,
    parameter int          STEP         = 20,
    parameter int          ARENA_LEFT   = 341,
    parameter int          ARENA_RIGHT  = 712,
    parameter int          LASER_TOP    = 317,
    parameter int          LASER_BOTTOM = 617,
    parameter int          WARN_FRAMES  = 60,
    parameter int          FIRE_FRAMES  = 30,
    parameter int          NUM_ROUNDS   = 4,
    parameter logic [3:0]  SELECT_CODE  = 4'b0011,
    parameter logic [11:0] WARN_RGB     = 12'h800,
    parameter logic [11:0] FIRE_RGB     = 12'hfff
) (
    input  logic                 pclk,
    input  logic                 rst,
    laser_sweep_obstacle_if.slave bus
);

    localparam logic [11:0] ARENA_LEFT_C  = 12'(ARENA_LEFT);
    localparam logic [11:0] ARENA_RIGHT_C = 12'(ARENA_RIGHT);
    localparam logic [11:0] TOP_C         = 12'(LASER_TOP);
    localparam logic [11:0] BOTTOM_C      = 12'(LASER_BOTTOM);
    localparam logic [11:0] WIDTH_M1_C    = 12'(LASER_WIDTH - 1);
    localparam logic [11:0] STEP_C        = 12'(STEP);
    localparam logic [11:0] SPACING_C     = 12'(SPACING);
    localparam logic [15:0] WARN_LAST_C   = 16'(WARN_FRAMES - 1);
    localparam logic [15:0] FIRE_LAST_C   = 16'(FIRE_FRAMES - 1);
    localparam logic [7:0]  ROUNDS_C      = 8'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WARN  = 3'd1,
        S_FIRE  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  round_cnt_q, round_cnt_d;
    logic [11:0] offset_q, offset_d;
    logic [11:0] rgb_q, rgb_d;
    logic [11:0] obstacle_x_q, obstacle_x_d;
    logic [11:0] obstacle_y_q, obstacle_y_d;
    logic        firing_q, firing_d;
    logic        done_q, done_d;

    logic        frame_tick_s;
    logic        armed_s;
    logic        bar_hit_s;
    logic        warn_on_s;
    logic [11:0] bar_left_s;
    logic [11:0] offset_step_s;
    logic [7:0]  round_next_s;

    assign frame_tick_s  = (bus.hcount_in == 12'd0) && (bus.vcount_in == 12'd0);
    assign armed_s       = bus.game_on && (bus.selected == SELECT_CODE);
    assign offset_step_s = offset_q + STEP_C;
    assign round_next_s  = round_cnt_q + 8'd1;

`ifdef LASER_WARN_BLINK_EN
    assign warn_on_s = ~frame_cnt_q[3];
`else
    assign warn_on_s = 1'b1;
`endif

    // Bar coverage of the current pixel; overlapping bars simply OR together
    always_comb begin
        bar_hit_s  = 1'b0;
        bar_left_s = 12'd0;
        for (int i = 0; i < NUM_LASERS; i++) begin
            bar_left_s = ARENA_LEFT_C + 12'(i * SPACING) + offset_q;
            bar_hit_s  = bar_hit_s | ((bus.hcount_in >= bar_left_s) &&
                                      (bus.hcount_in <= bar_left_s + WIDTH_M1_C));
        end
        bar_hit_s = bar_hit_s & (bus.hcount_in <= ARENA_RIGHT_C) &
                    (bus.vcount_in >= TOP_C) & (bus.vcount_in <= BOTTOM_C);
    end

    // Sequencer next state; abort out of any active state takes priority over frame ticks
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        round_cnt_d = round_cnt_q;
        offset_d    = offset_q;
        if ((state_q != S_IDLE) && !armed_s) begin
            state_d     = S_IDLE;
            frame_cnt_d = 16'd0;
            round_cnt_d = 8'd0;
            offset_d    = 12'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    frame_cnt_d = 16'd0;
                    round_cnt_d = 8'd0;
                    offset_d    = 12'd0;
                    if (armed_s) begin
                        state_d = S_WARN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WARN: begin
                    if (frame_tick_s && (frame_cnt_q == WARN_LAST_C)) begin
                        state_d     = S_FIRE;
                        frame_cnt_d = 16'd0;
                    end else if (frame_tick_s) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        frame_cnt_d = frame_cnt_q;
                    end
                end
                S_FIRE: begin
                    if (frame_tick_s && (frame_cnt_q == FIRE_LAST_C)) begin
                        state_d     = S_SHIFT;
                        frame_cnt_d = 16'd0;
                    end else if (frame_tick_s) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        frame_cnt_d = frame_cnt_q;
                    end
                end
                S_SHIFT: begin
                    frame_cnt_d = 16'd0;
                    round_cnt_d = round_next_s;
                    if (offset_step_s >= SPACING_C) begin
                        offset_d = offset_step_s - SPACING_C;
                    end else begin
                        offset_d = offset_step_s;
                    end
                    if (round_next_s == ROUNDS_C) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WARN;
                    end
                end
                S_DONE: begin
                    state_d     = S_IDLE;
                    frame_cnt_d = 16'd0;
                    round_cnt_d = 8'd0;
                    offset_d    = 12'd0;
                end
                default: begin
                    state_d     = S_IDLE;
                    frame_cnt_d = 16'd0;
                    round_cnt_d = 8'd0;
                    offset_d    = 12'd0;
                end
            endcase
        end
    end

    // Pixel colour and status outputs, registered one cycle behind the pixel stream
    always_comb begin
        rgb_d        = bus.rgb_in;
        obstacle_x_d = 12'd0;
        obstacle_y_d = 12'd0;
        firing_d     = 1'b0;
        done_d       = (state_d == S_DONE);
        case (state_q)
            S_WARN: begin
                if (bar_hit_s && warn_on_s) begin
                    rgb_d = WARN_RGB;
                end else begin
                    rgb_d = bus.rgb_in;
                end
            end
            S_FIRE: begin
                if (bar_hit_s) begin
                    rgb_d = FIRE_RGB;
                end else begin
                    rgb_d = bus.rgb_in;
                end
                obstacle_x_d = ARENA_LEFT_C + offset_q;
                obstacle_y_d = TOP_C;
                firing_d     = 1'b1;
            end
            default: begin
                rgb_d = bus.rgb_in;
            end
        endcase
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            frame_cnt_q  <= 16'd0;
            round_cnt_q  <= 8'd0;
            offset_q     <= 12'd0;
            rgb_q        <= 12'd0;
            obstacle_x_q <= 12'd0;
            obstacle_y_q <= 12'd0;
            firing_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            round_cnt_q  <= round_cnt_d;
            offset_q     <= offset_d;
            rgb_q        <= rgb_d;
            obstacle_x_q <= obstacle_x_d;
            obstacle_y_q <= obstacle_y_d;
            firing_q     <= firing_d;
            done_q       <= done_d;
        end
    end

    assign bus.rgb_out    = rgb_q;
    assign bus.obstacle_x = obstacle_x_q;
    assign bus.obstacle_y = obstacle_y_q;
    assign bus.firing     = firing_q;
    assign bus.done       = done_q;

endmodule
